// File: rtl/accelerator_if.sv
// Bus bundle for the leaky integrate-and-fire accelerator.
// master drives the neuron inputs; slave is the accelerator itself.
interface accelerator_if;
    logic [3:0]   spike_in;
    logic [127:0] weight;
    logic [31:0]  v_threshold;
    logic [31:0]  current_potential;
    logic [2:0]   decay_rate;
    logic         spiked;
    logic [31:0]  potential_to_mem;

    modport master (
        output spike_in,
        output weight,
        output v_threshold,
        output current_potential,
        output decay_rate,
        input  spiked,
        input  potential_to_mem
    );

    modport slave (
        input  spike_in,
        input  weight,
        input  v_threshold,
        input  current_potential,
        input  decay_rate,
        output spiked,
        output potential_to_mem
    );
endinterface

// File: rtl/accelerator.sv
// Single-neuron leaky integrate-and-fire update with one cycle of latency.
// The potential leaks by a right-shift term, spiking lanes add their
// weights, and the result is compared against the threshold. A firing
// neuron writes back zero.
// Build option ACCELERATOR_SATURATE_EN: when defined, the input sum and
// the new potential clamp at 32'hFFFFFFFF instead of wrapping mod 2^32.
module accelerator (
    input  logic               CLK,
    input  logic               RESET,
    accelerator_if.slave       bus
);

    logic [31:0] decayed;
    logic [31:0] new_potential;
    logic        fire;

    // Leak: shift of zero means no leak, not a full drain.
    always_comb begin
        decayed = bus.current_potential;
        if (bus.decay_rate != 3'd0) begin
            decayed = bus.current_potential - (bus.current_potential >> bus.decay_rate);
        end
    end

`ifdef ACCELERATOR_SATURATE_EN
    logic [33:0] sum_wide;
    logic [31:0] in_sum;
    logic [32:0] np_wide;

    // Integrate spiking lanes and decayed potential with clamping.
    always_comb begin
        sum_wide = 34'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.spike_in[i]) begin
                sum_wide = sum_wide + {2'b00, bus.weight[32*i +: 32]};
            end
        end
        in_sum = (sum_wide[33:32] != 2'b00) ? 32'hFFFF_FFFF : sum_wide[31:0];
        np_wide = {1'b0, decayed} + {1'b0, in_sum};
        new_potential = np_wide[32] ? 32'hFFFF_FFFF : np_wide[31:0];
    end
`else
    logic [31:0] in_sum;

    // Integrate spiking lanes and decayed potential, wrapping mod 2^32.
    always_comb begin
        in_sum = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.spike_in[i]) begin
                in_sum = in_sum + bus.weight[32*i +: 32];
            end
        end
        new_potential = decayed + in_sum;
    end
`endif

    assign fire = (new_potential >= bus.v_threshold);

    // Register the fire flag and write-back value; reset discards the update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.spiked           <= 1'b0;
            bus.potential_to_mem <= 32'd0;
        end else begin
            bus.spiked           <= fire;
            bus.potential_to_mem <= fire ? 32'd0 : new_potential;
        end
    end

endmodule

// File: tb/tb_accelerator.sv
// Directed bench for the accelerator: each step drives one input set,
// waits one edge, and checks spiked and potential_to_mem.
module tb_accelerator;

    logic CLK;
    logic RESET;
    int   errors;
    int   checks;

    accelerator_if bus ();

    accelerator dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sp,
                         input logic [31:0] l0, input logic [31:0] l1,
                         input logic [31:0] l2, input logic [31:0] l3,
                         input logic [31:0] thr, input logic [31:0] cp,
                         input logic [2:0] dr);
        bus.spike_in          = sp;
        bus.weight            = {l3, l2, l1, l0};
        bus.v_threshold       = thr;
        bus.current_potential = cp;
        bus.decay_rate        = dr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RESET  = 1'b1;

        // Reset for two edges with arbitrary inputs that would otherwise fire.
        drive(4'b1111, 32'd500, 32'd7, 32'd9, 32'd11, 32'd0, 32'd1234, 3'd3);
        drive(4'b0101, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd99, 3'd1);
        check("reset_spiked", {31'd0, bus.spiked}, 32'd0);
        check("reset_pot", bus.potential_to_mem, 32'd0);
        RESET = 1'b0;

        // 20 - (20>>4) = 19, no spikes.
        drive(4'b0000, 32'd64, 32'd64, 32'd64, 32'd64, 32'd78, 32'd20, 3'd4);
        check("leak_only_spiked", {31'd0, bus.spiked}, 32'd0);
        check("leak_only_pot", bus.potential_to_mem, 32'd19);

        // 19 + 64 = 83 >= 78 fires.
        drive(4'b0001, 32'd64, 32'd64, 32'd64, 32'd64, 32'd78, 32'd20, 3'd4);
        check("fire_spiked", {31'd0, bus.spiked}, 32'd1);
        check("fire_pot", bus.potential_to_mem, 32'd0);

        // Pulse drops when the spike input goes away.
        drive(4'b0000, 32'd64, 32'd64, 32'd64, 32'd64, 32'd78, 32'd20, 3'd4);
        check("pulse_end_spiked", {31'd0, bus.spiked}, 32'd0);
        check("pulse_end_pot", bus.potential_to_mem, 32'd19);

        // Equality fires.
        drive(4'b0001, 32'd78, 32'd0, 32'd0, 32'd0, 32'd78, 32'd0, 3'd4);
        check("eq_spiked", {31'd0, bus.spiked}, 32'd1);
        check("eq_pot", bus.potential_to_mem, 32'd0);

        // One below threshold does not fire.
        drive(4'b0001, 32'd77, 32'd0, 32'd0, 32'd0, 32'd78, 32'd0, 3'd4);
        check("below_spiked", {31'd0, bus.spiked}, 32'd0);
        check("below_pot", bus.potential_to_mem, 32'd77);

        // decay_rate 0 leaves the potential untouched.
        drive(4'b0000, 32'd5, 32'd5, 32'd5, 32'd5, 32'd100, 32'd50, 3'd0);
        check("noleak_spiked", {31'd0, bus.spiked}, 32'd0);
        check("noleak_pot", bus.potential_to_mem, 32'd50);

        // 100 - 25 = 75, plus 4*10 = 115.
        drive(4'b1111, 32'd10, 32'd10, 32'd10, 32'd10, 32'd1000, 32'd100, 3'd2);
        check("all_lanes_spiked", {31'd0, bus.spiked}, 32'd0);
        check("all_lanes_pot", bus.potential_to_mem, 32'd115);

        // Lane selection: 2 + 8 = 10, then 1 + 4 = 5.
        drive(4'b1010, 32'd1, 32'd2, 32'd4, 32'd8, 32'd1000, 32'd0, 3'd1);
        check("lanes_1010_pot", bus.potential_to_mem, 32'd10);
        drive(4'b0101, 32'd1, 32'd2, 32'd4, 32'd8, 32'd1000, 32'd0, 3'd1);
        check("lanes_0101_pot", bus.potential_to_mem, 32'd5);

        // Maximum leak shift: 1000 - (1000>>7) = 993.
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2000, 32'd1000, 3'd7);
        check("decay7_pot", bus.potential_to_mem, 32'd993);

        // Threshold 0 always fires.
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 3'd1);
        check("thr0_spiked", {31'd0, bus.spiked}, 32'd1);
        check("thr0_pot", bus.potential_to_mem, 32'd0);

        // Potential overflow and input-sum overflow.
`ifdef ACCELERATOR_SATURATE_EN
        drive(4'b0001, 32'h20, 32'd0, 32'd0, 32'd0, 32'd78, 32'hFFFF_FFF0, 3'd0);
        check("ovf_spiked", {31'd0, bus.spiked}, 32'd1);
        check("ovf_pot", bus.potential_to_mem, 32'd0);
        drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'd0, 3'd0);
        check("sum_ovf_spiked", {31'd0, bus.spiked}, 32'd1);
        check("sum_ovf_pot", bus.potential_to_mem, 32'd0);
`else
        drive(4'b0001, 32'h20, 32'd0, 32'd0, 32'd0, 32'd78, 32'hFFFF_FFF0, 3'd0);
        check("ovf_spiked", {31'd0, bus.spiked}, 32'd0);
        check("ovf_pot", bus.potential_to_mem, 32'h10);
        drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'd0, 3'd0);
        check("sum_ovf_spiked", {31'd0, bus.spiked}, 32'd0);
        check("sum_ovf_pot", bus.potential_to_mem, 32'hFFFF_FFFC);
`endif

        // Mid-operation reset discards a firing update, then operation resumes.
        RESET = 1'b1;
        drive(4'b0001, 32'd64, 32'd0, 32'd0, 32'd0, 32'd78, 32'd20, 3'd4);
        check("midreset_spiked", {31'd0, bus.spiked}, 32'd0);
        check("midreset_pot", bus.potential_to_mem, 32'd0);
        RESET = 1'b0;
        drive(4'b0000, 32'd64, 32'd0, 32'd0, 32'd0, 32'd78, 32'd20, 3'd4);
        check("resume_spiked", {31'd0, bus.spiked}, 32'd0);
        check("resume_pot", bus.potential_to_mem, 32'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accelerator.md
ACCELERATOR -- requirements
Module: accelerator

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 spike_in  input  4  spike flags of the 4 presynaptic inputs; bit i selects weight lane i.
REQ-005 weight  input  128  four unsigned 32-bit weights; lane i = weight[32*i+31:32*i].
REQ-006 v_threshold  input  32  unsigned firing threshold.
REQ-007 current_potential  input  32  unsigned membrane potential read from memory.
REQ-008 decay_rate  input  3  leak shift amount, 0..7.
REQ-009 spiked  output  1  registered fire flag.
REQ-010 potential_to_mem  output  32  registered updated potential for write-back.

Function
REQ-011 All inputs SHALL be sampled on every rising CLK edge; there is no valid/ready handshake.
REQ-012 The decay term SHALL be computed as follows:
- decay_rate = 0: decayed = current_potential (no leak).
- decay_rate = 1..7: decayed = current_potential - (current_potential >> decay_rate), logical shift.
REQ-013 The input sum SHALL be the sum of lane i over all i where spike_in[i] = 1; spike_in = 0 gives a sum of 0.
REQ-014 new_potential SHALL equal decayed + input sum; overflow handling is set by REQ-022.
REQ-015 Firing SHALL occur if new_potential >= v_threshold (unsigned compare, equality fires).
- On fire: spiked <= 1 and potential_to_mem <= 0.
- Otherwise: spiked <= 0 and potential_to_mem <= new_potential.
REQ-016 Latency SHALL be exactly 1 cycle: outputs reflect inputs sampled at edge N, valid after edge N until edge N+1.
REQ-017 spiked SHALL be recomputed every cycle, so it is a one-cycle pulse unless firing conditions persist.
REQ-018 v_threshold = 0 SHALL make every cycle fire.
REQ-019 Inputs that are X/undriven before first use SHALL not be relied upon; the bench drives RESET before sampling outputs.

Reset
REQ-020 While RESET = 1 at a rising edge: spiked <= 0 and potential_to_mem <= 0, overriding all datapath results.
REQ-021 Reset asserted mid-operation SHALL discard the in-flight update; normal operation resumes on the first edge with RESET = 0.

Configuration
REQ-022 Macro ACCELERATOR_SATURATE_EN SHALL select overflow handling:
- Defined: the input sum and new_potential saturate at 32'hFFFFFFFF; intermediate sums use at least 34 bits.
- Undefined: the input sum and new_potential wrap modulo 2^32.

Verification
REQ-023 RESET = 1 for 2 edges with arbitrary inputs -> spiked = 0, potential_to_mem = 0.
REQ-024 RESET = 0, spike_in = 0000, weight = 64, v_threshold = 78, current_potential = 20, decay_rate = 4 -> next edge: potential_to_mem = 19, spiked = 0.
REQ-025 Same as REQ-024 but spike_in = 0001 -> 19 + 64 = 83 >= 78, so spiked = 1 and potential_to_mem = 0; next cycle with spike_in = 0000 -> spiked = 0.
REQ-026 Threshold equality and leak disable:
- current_potential = 0, spike_in = 0001, lane0 = 78, v_threshold = 78 -> spiked = 1, potential_to_mem = 0.
- decay_rate = 0, current_potential = 50, spike_in = 0, v_threshold = 100 -> potential_to_mem = 50, spiked = 0.
REQ-027 All lanes = 10, spike_in = 1111, current_potential = 100, decay_rate = 2, v_threshold = 1000 -> 75 + 40 = 115, spiked = 0.
REQ-028 current_potential = 32'hFFFFFFF0, decay_rate = 0, spike_in = 0001, lane0 = 32'h20, v_threshold = 78:
- With ACCELERATOR_SATURATE_EN: spiked = 1, potential_to_mem = 0.
- Without it: potential_to_mem = 32'h10, spiked = 0.
